// File: rtl/cp0_compare_array.sv
// ---------------------------------------------------------------------------
// cp0_compare_array
//
// Free-running CP0 Count register with CH independent Compare channels. Each
// channel owns a sticky timer-interrupt pending bit and an enable bit. Count
// advances once every PRESCALE clocks.
//
// Register map (waddr / raddr):
//   0          Count
//   1..CH      Compare[0..CH-1]
//   CH+1       Enable (bits [CH-1:0], upper bits read 0)
//   others     read 0, writes ignored
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   count_hold  (only with CP0_COUNT_HOLD_EN) freezes prescaler and Count
//   we          register write strobe
//   waddr       write address
//   write_data  write data
//   raddr       read address
//   read_data   combinational read data for raddr
//   count_out   current Count value
//   irq         per-channel pending timer interrupt
//   irq_any     OR of irq
//
// Optional feature macro: CP0_COUNT_HOLD_EN
// ---------------------------------------------------------------------------
module cp0_compare_array #(
    parameter int WIDTH    = 32,
    parameter int CH       = 4,
    parameter int PRESCALE = 2,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CP0_COUNT_HOLD_EN
    input  logic              count_hold,
`endif
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  read_data,
    output logic [WIDTH-1:0]  count_out,
    output logic [CH-1:0]     irq,
    output logic              irq_any
);

    // A one-cycle prescaler still needs a 1-bit counter to keep widths legal.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    pre_cnt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] compare [CH];
    logic [CH-1:0]    enable;
    logic [CH-1:0]    pending;
    logic [CH-1:0]    eq;
    logic [CH-1:0]    eq_d;
    logic [CH-1:0]    match;
    logic [CH-1:0]    cmp_wr;
    logic             count_wr;
    logic             enable_wr;
    logic             tick;
    logic             run;

`ifdef CP0_COUNT_HOLD_EN
    assign run = ~count_hold;
`else
    assign run = 1'b1;
`endif

    assign tick = (pre_cnt == PW'(PRESCALE - 1));

    always_comb begin
        count_wr  = we && (waddr == '0);
        enable_wr = we && (waddr == ADDR_W'(CH + 1));
        cmp_wr    = '0;
        for (int i = 0; i < CH; i++) begin
            cmp_wr[i] = we && (waddr == ADDR_W'(i + 1));
        end
    end

    // A match event fires only on entry into equality, so a Count value held
    // for several prescaler cycles raises the interrupt once.
    always_comb begin
        eq = '0;
        for (int i = 0; i < CH; i++) begin
            eq[i] = (count == compare[i]);
        end
        match = eq & ~eq_d & enable;
    end

    // A Count write restarts the prescale period and takes priority over a
    // tick landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            pre_cnt <= '0;
        end else if (count_wr) begin
            count   <= write_data;
            pre_cnt <= '0;
        end else if (run) begin
            if (tick) begin
                count   <= count + WIDTH'(1);
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                compare[i] <= '1;
            end
            enable <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cmp_wr[i]) begin
                    compare[i] <= write_data;
                end
            end
            if (enable_wr) begin
                enable <= write_data[CH-1:0];
            end
        end
    end

    // Writing a Compare register acknowledges its interrupt; that write wins
    // over a match event arriving on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_d    <= '0;
            pending <= '0;
        end else begin
            eq_d    <= eq;
            pending <= (pending | match) & ~cmp_wr;
        end
    end

    always_comb begin
        read_data = '0;
        if (raddr == '0) begin
            read_data = count;
        end
        for (int i = 0; i < CH; i++) begin
            if (raddr == ADDR_W'(i + 1)) begin
                read_data = compare[i];
            end
        end
        if (raddr == ADDR_W'(CH + 1)) begin
            read_data[CH-1:0] = enable;
        end
    end

    assign count_out = count;
    assign irq       = pending;
    assign irq_any   = |pending;

endmodule

// File: tb/tb_cp0_compare_array.sv
// ---------------------------------------------------------------------------
// tb_cp0_compare_array
//
// Self-checking bench for cp0_compare_array. The main instance (PRESCALE=2,
// CH=4) is shadowed by a reference model; every cycle the expected Count and
// pending bits are queued when inputs are driven and popped when the DUT
// outputs are sampled on the falling edge. A second instance with PRESCALE=3
// exercises Count writes against the prescaler and, with CP0_COUNT_HOLD_EN,
// the count_hold input.
// ---------------------------------------------------------------------------
module tb_cp0_compare_array;

    localparam int WIDTH    = 32;
    localparam int CH       = 4;
    localparam int PRESCALE = 2;
    localparam int ADDR_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  write_data;
    logic [ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]  read_data;
    logic [WIDTH-1:0]  count_out;
    logic [CH-1:0]     irq;
    logic              irq_any;

    logic              we3;
    logic [ADDR_W-1:0] waddr3;
    logic [WIDTH-1:0]  wdata3;
    logic [ADDR_W-1:0] raddr3;
    logic [WIDTH-1:0]  rdata3;
    logic [WIDTH-1:0]  count3;
    logic [CH-1:0]     irq3;
    logic              irq_any3;

`ifdef CP0_COUNT_HOLD_EN
    logic hold0;
    logic hold3;
`endif

    always #5 clk = ~clk;

    cp0_compare_array #(
        .WIDTH(WIDTH), .CH(CH), .PRESCALE(PRESCALE), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef CP0_COUNT_HOLD_EN
        .count_hold(hold0),
`endif
        .we(we),
        .waddr(waddr),
        .write_data(write_data),
        .raddr(raddr),
        .read_data(read_data),
        .count_out(count_out),
        .irq(irq),
        .irq_any(irq_any)
    );

    cp0_compare_array #(
        .WIDTH(WIDTH), .CH(CH), .PRESCALE(3), .ADDR_W(ADDR_W)
    ) dut3 (
        .clk(clk),
        .rst(rst),
`ifdef CP0_COUNT_HOLD_EN
        .count_hold(hold3),
`endif
        .we(we3),
        .waddr(waddr3),
        .write_data(wdata3),
        .raddr(raddr3),
        .read_data(rdata3),
        .count_out(count3),
        .irq(irq3),
        .irq_any(irq_any3)
    );

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic [CH-1:0]    irq;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] m_count;
    int               m_pre;
    logic [WIDTH-1:0] m_cmp [CH];
    logic [CH-1:0]    m_en;
    logic [CH-1:0]    m_pend;
    logic [CH-1:0]    m_eqd;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_count = '0;
        m_pre   = 0;
        for (int i = 0; i < CH; i++) m_cmp[i] = '1;
        m_en    = '0;
        m_pend  = '0;
        m_eqd   = '0;
        sb_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven, queue
    // the expected post-edge outputs, then clock the DUT and compare.
    task automatic step();
        logic [CH-1:0] eq_now;
        logic [CH-1:0] hit;
        exp_t          e;
        for (int i = 0; i < CH; i++) eq_now[i] = (m_count == m_cmp[i]);
        hit = eq_now & ~m_eqd & m_en;
        for (int i = 0; i < CH; i++) begin
            if (we && waddr == ADDR_W'(i + 1)) begin
                m_pend[i] = 1'b0;
                m_cmp[i]  = write_data;
            end else if (hit[i]) begin
                m_pend[i] = 1'b1;
            end
        end
        m_eqd = eq_now;
        if (we && waddr == '0) begin
            m_count = write_data;
            m_pre   = 0;
        end else if (m_pre == PRESCALE - 1) begin
            m_count = m_count + 32'd1;
            m_pre   = 0;
        end else begin
            m_pre = m_pre + 1;
        end
        if (we && waddr == ADDR_W'(CH + 1)) m_en = write_data[CH-1:0];
        e.count = m_count;
        e.irq   = m_pend;
        sb_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        checkOutput("sb_count", count_out, e.count);
        checkOutput("sb_irq", 32'(irq), 32'(e.irq));
        checkOutput("sb_irq_any", 32'(irq_any), 32'(|e.irq));
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] addr,
                                 input logic [WIDTH-1:0] data);
        we         = 1'b1;
        waddr      = addr;
        write_data = data;
        step();
        we         = 1'b0;
        waddr      = '0;
        write_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic waitCount(input logic [WIDTH-1:0] target, input int budget,
                             input string tag);
        int k = 0;
        while (count_out !== target && k < budget) begin
            step();
            k++;
        end
        checkOutput(tag, count_out, target);
    endtask

    task automatic readCheck(input logic [ADDR_W-1:0] addr,
                             input logic [WIDTH-1:0] exp, input string tag);
        raddr = addr;
        #1;
        checkOutput(tag, read_data, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        we         = 1'b0;
        waddr      = '0;
        write_data = '0;
        raddr      = '0;
        we3        = 1'b0;
        waddr3     = '0;
        wdata3     = '0;
        raddr3     = '0;
`ifdef CP0_COUNT_HOLD_EN
        hold0      = 1'b0;
        hold3      = 1'b0;
`endif
        modelReset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_count", count_out, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_irq_any", 32'(irq_any), 32'd0);
        readCheck(4'd1, 32'hFFFF_FFFF, "rst_cmp0");
        readCheck(4'd5, 32'd0, "rst_enable");
        rst = 1'b0;

        // Basic match: Count reaches 5 after 10 clocks, irq one clock later
        applyStimulus(4'd5, 32'h1);
        applyStimulus(4'd1, 32'd5);
        idle(8);
        checkOutput("basic_cnt5", count_out, 32'd5);
        checkOutput("basic_irq_pre", 32'(irq[0]), 32'd0);
        idle(1);
        checkOutput("basic_irq_set", 32'(irq[0]), 32'd1);
        idle(4);
        checkOutput("basic_cnt7", count_out, 32'd7);
        checkOutput("basic_sticky", 32'(irq[0]), 32'd1);
        checkOutput("basic_any", 32'(irq_any), 32'd1);

        // Compare write clears pending; re-arm at 20
        applyStimulus(4'd1, 32'd20);
        checkOutput("clr_irq", 32'(irq[0]), 32'd0);
        waitCount(32'd20, 60, "reach20");
        checkOutput("rearm_pre", 32'(irq[0]), 32'd0);
        idle(1);
        checkOutput("rearm_set", 32'(irq[0]), 32'd1);

        // Compare write on the match-event edge wins
        applyStimulus(4'd1, 32'd30);
        waitCount(32'd30, 60, "reach30");
        applyStimulus(4'd1, 32'd50);
        checkOutput("coll_irq", 32'(irq[0]), 32'd0);
        idle(1);
        checkOutput("coll_irq2", 32'(irq[0]), 32'd0);

        // Wrap-around of Count onto Compare1 = 0
        applyStimulus(4'd5, 32'h2);
        applyStimulus(4'd2, 32'd0);
        applyStimulus(4'd0, 32'hFFFF_FFFF);
        checkOutput("wrap_load", count_out, 32'hFFFF_FFFF);
        idle(1);
        checkOutput("wrap_hold", count_out, 32'hFFFF_FFFF);
        idle(1);
        checkOutput("wrap_zero", count_out, 32'd0);
        checkOutput("wrap_irq_pre", 32'(irq[1]), 32'd0);
        idle(1);
        checkOutput("wrap_irq", 32'(irq[1]), 32'd1);

        // Disabled channel, then enable while equality already holds
        applyStimulus(4'd3, 32'd3);
        waitCount(32'd4, 20, "reach4");
        checkOutput("dis_irq", 32'(irq[2]), 32'd0);
        applyStimulus(4'd0, 32'd3);
        checkOutput("late_cnt3", count_out, 32'd3);
        applyStimulus(4'd5, 32'h6);
        checkOutput("late_irq_a", 32'(irq[2]), 32'd0);
        idle(1);
        checkOutput("late_irq_b", 32'(irq[2]), 32'd0);
        applyStimulus(4'd0, 32'd2);
        waitCount(32'd3, 10, "reach3");
        checkOutput("late_irq_c", 32'(irq[2]), 32'd0);
        idle(1);
        checkOutput("late_irq_set", 32'(irq[2]), 32'd1);

        // Clearing an enable keeps the pending bit
        applyStimulus(4'd5, 32'h4);
        checkOutput("en_clr_keep", 32'(irq[1]), 32'd1);

        // Register reads and unmapped addresses
        readCheck(4'd5, 32'h4, "rd_enable");
        readCheck(4'd2, 32'd0, "rd_cmp1");
        idle(1);
        readCheck(4'd3, 32'd3, "rd_cmp2");
        readCheck(4'd1, 32'd50, "rd_cmp0");
        idle(1);
        readCheck(4'd6, 32'd0, "rd_unmapped6");
        readCheck(4'd15, 32'd0, "rd_unmapped15");
        idle(1);
        applyStimulus(4'd9, 32'hDEAD_BEEF);
        readCheck(4'd9, 32'd0, "rd_unmapped9");
        idle(1);

        // Reading Count during a Count write shows the old value
        raddr      = '0;
        we         = 1'b1;
        waddr      = '0;
        write_data = 32'd123;
        #1;
        checkOutput("rd_count_old", read_data, m_count);
        step();
        we         = 1'b0;
        write_data = '0;
        checkOutput("cnt_written", count_out, 32'd123);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_count", count_out, 32'd0);
        checkOutput("arst_irq", 32'(irq), 32'd0);
        checkOutput("arst_any", 32'(irq_any), 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        readCheck(4'd2, 32'hFFFF_FFFF, "arst_cmp1");
        idle(2);

        // PRESCALE=3 instance: Count write holds value for a full period
        we3    = 1'b1;
        waddr3 = '0;
        wdata3 = 32'd100;
        step();
        we3    = 1'b0;
        wdata3 = '0;
        checkOutput("p3_c1", count3, 32'd100);
        idle(1);
        checkOutput("p3_c2", count3, 32'd100);
        idle(1);
        checkOutput("p3_c3", count3, 32'd100);
        idle(1);
        checkOutput("p3_inc", count3, 32'd101);
        checkOutput("p3_read", rdata3, 32'd101);
        checkOutput("p3_irq_any", 32'(irq_any3), 32'd0);
        checkOutput("p3_irq", 32'(irq3), 32'd0);

`ifdef CP0_COUNT_HOLD_EN
        hold3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            checkOutput("hold_frozen", count3, 32'd101);
        end
        hold3 = 1'b0;
        idle(2);
        checkOutput("hold_rel_a", count3, 32'd101);
        idle(1);
        checkOutput("hold_rel_b", count3, 32'd102);
        hold3  = 1'b1;
        we3    = 1'b1;
        wdata3 = 32'd200;
        step();
        we3    = 1'b0;
        wdata3 = '0;
        checkOutput("hold_write", count3, 32'd200);
        idle(3);
        checkOutput("hold_write_frozen", count3, 32'd200);
        hold3 = 1'b0;
        idle(3);
        checkOutput("hold_write_rel", count3, 32'd201);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
